// File: rtl/imem_loader.sv
// Instruction-memory loader: length-prefixed byte stream -> sequential little-endian word writes.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_loaded,
    output logic              cpu_hold,
    output logic              chk_err
);

    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHK,
        S_DONE
    } state_t;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [WORD_W-1:0] shift_q;
    logic [CNT_W-1:0]  target;
    logic              accept;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] xor_q;
`else
    logic              last_q;
    assign chk_err = 1'b0;
`endif

    assign accept = byte_valid && byte_ready;

    // Load sequencer; the write-finish block after the case owns address/count updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            words_loaded <= '0;
            cpu_hold     <= 1'b1;
            byte_cnt     <= '0;
            shift_q      <= '0;
            target       <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            xor_q        <= '0;
            chk_err      <= 1'b0;
`else
            last_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_LEN;
                        byte_ready   <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        cpu_hold     <= 1'b1;
                        words_loaded <= '0;
                        byte_cnt     <= '0;
                        mem_addr     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q        <= '0;
                        chk_err      <= 1'b0;
`else
                        last_q       <= 1'b0;
`endif
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        // Zero or anything beyond the memory depth loads the full memory.
                        if (byte_in == '0 || 32'(byte_in) > DEPTH) begin
                            target <= CNT_W'(DEPTH);
                        end else begin
                            target <= CNT_W'(byte_in);
                        end
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        shift_q  <= {byte_in, shift_q[WORD_W-1:BYTE_W]};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        xor_q    <= xor_q ^ byte_in;
`endif
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= {byte_in, shift_q[WORD_W-1:BYTE_W]};
                            if (words_loaded + CNT_W'(1) == target) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state  <= S_CHK;
`else
                                last_q <= 1'b1;
`endif
                            end
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (accept) begin
                        chk_err    <= (byte_in != xor_q);
                        cpu_hold   <= (byte_in != xor_q);
                        state      <= S_DONE;
                        byte_ready <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
`endif
                default: begin
                    state      <= S_IDLE;
                    byte_ready <= 1'b0;
                end
            endcase

            // Write-finish cycle: retire the strobe and advance the address.
            if (mem_we) begin
                mem_we       <= 1'b0;
                mem_addr     <= mem_addr + ADDR_W'(1);
                words_loaded <= words_loaded + CNT_W'(1);
`ifndef IMEM_LOADER_CHECKSUM_EN
                if (last_q) begin
                    state      <= S_DONE;
                    byte_ready <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    cpu_hold   <= 1'b0;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized directed bench for imem_loader: stream images, compare writes against a byte-level model.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [6:0]  words_loaded;
    logic        cpu_hold;
    logic        chk_err;

    imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .busy         (busy),
        .done         (done),
        .words_loaded (words_loaded),
        .cpu_hold     (cpu_hold),
        .chk_err      (chk_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observation log, written only by the monitor.
    int          cyc = 0;
    int          hs_q[$];
    int          we_cyc_q[$];
    logic [5:0]  addr_q[$];
    logic [31:0] data_q[$];
    int          done_cyc = -1;
    bit          done_seen = 1'b0;

    logic [7:0]  img[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n || (start && !busy)) begin
            hs_q.delete();
            we_cyc_q.delete();
            addr_q.delete();
            data_q.delete();
            done_cyc  = -1;
            done_seen = 1'b0;
        end else begin
            if (byte_valid && byte_ready) hs_q.push_back(cyc);
            if (mem_we) begin
                we_cyc_q.push_back(cyc);
                addr_q.push_back(mem_addr);
                data_q.push_back(mem_wdata);
            end
            if (done && !done_seen) begin
                done_cyc  = cyc;
                done_seen = 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_chk_err", 32'(chk_err), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_words_loaded", 32'(words_loaded), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int gap;
        int budget;
        bit ok;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        byte_in    = b;
        byte_valid = 1'b1;
        ok         = 1'b0;
        budget     = 0;
        while (!ok && budget < 50) begin
            @(negedge clk);
            ok = byte_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        byte_valid = 1'b0;
        if (!ok) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    // Streams len_byte + img (+ checksum) and checks every write, the latencies and final status.
    task automatic run_load(input int len_byte, input int max_gap, input bit bad_chk);
        int          n;
        int          waited;
        logic [31:0] exp_w[$];
        logic [7:0]  x;
        n = (len_byte == 0 || len_byte > 64) ? 64 : len_byte;
        x = 8'h00;
        for (int k = 0; k < n; k++) begin
            exp_w.push_back(32'(img[4*k]) | (32'(img[4*k+1]) << 8) |
                            (32'(img[4*k+2]) << 16) | (32'(img[4*k+3]) << 24));
        end
        for (int i = 0; i < 4*n; i++) x = x ^ img[i];

        pulse_start();
        send_byte(8'(len_byte), max_gap);
        for (int i = 0; i < 4*n; i++) send_byte(img[i], max_gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(bad_chk ? ~x : x, max_gap);
`endif
        waited = 0;
        while (!done && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);

        check("write_count", 32'(data_q.size()), 32'(n));
        for (int k = 0; k < n && k < data_q.size(); k++) begin
            check($sformatf("addr_w%0d", k), 32'(addr_q[k]), 32'(k % 64));
            check($sformatf("data_w%0d", k), data_q[k], exp_w[k]);
            check($sformatf("we_latency_w%0d", k), 32'(we_cyc_q[k]), 32'(hs_q[4*k+4] + 1));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("chk_err", 32'(chk_err), 32'(bad_chk));
        check("cpu_hold", 32'(cpu_hold), 32'(bad_chk));
`else
        if (we_cyc_q.size() == n)
            check("done_latency", 32'(done_cyc), 32'(we_cyc_q[n-1] + 1));
        check("cpu_hold", 32'(cpu_hold), 32'd0);
        check("chk_err", 32'(chk_err), 32'd0);
`endif
        check("done", 32'(done), 32'd1);
        check("busy", 32'(busy), 32'd0);
        check("byte_ready_done", 32'(byte_ready), 32'd0);
        check("words_loaded", 32'(words_loaded), 32'(n));
        check("final_mem_addr", 32'(mem_addr), 32'(n % 64));
    endtask

    task automatic set_basic_image();
        img.delete();
        img.push_back(8'h13); img.push_back(8'h05); img.push_back(8'h40); img.push_back(8'h01);
        img.push_back(8'h93); img.push_back(8'h05); img.push_back(8'hC0); img.push_back(8'hFE);
    endtask

    task automatic set_random_image(input int nbytes);
        img.delete();
        for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom));
    endtask

    initial begin
        int n;
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic two-word image, continuous valid.
        set_basic_image();
        run_load(2, 0, 1'b0);
        check("basic_word0", data_q[0], 32'h01400513);
        check("basic_word1", data_q[1], 32'hFEC00593);

        // Full depth: length byte 0 means 64 words; address wraps back to 0.
        set_random_image(256);
        run_load(0, 0, 1'b0);

        // Throttled basic image.
        set_basic_image();
        run_load(2, 5, 1'b0);

        // Random lengths with random gaps.
        for (int t = 0; t < 3; t++) begin
            n = int'($urandom_range(64, 1));
            set_random_image(4*n);
            run_load(n, 3, 1'b0);
        end

        // Start while busy is ignored, then reset mid-load.
        set_basic_image();
        pulse_start();
        send_byte(8'h02, 0);
        for (int i = 0; i < 3; i++) send_byte(img[i], 0);
        pulse_start();
        check("busy_after_ignored_start", 32'(busy), 32'd1);
        send_byte(img[3], 0);
        @(negedge clk);
        @(negedge clk);
        check("midload_writes", 32'(data_q.size()), 32'd1);
        check("midload_addr0", 32'(addr_q[0]), 32'd0);
        check("midload_data0", data_q[0], 32'h01400513);
        check("midload_words_loaded", 32'(words_loaded), 32'd1);
        check("midload_mem_addr", 32'(mem_addr), 32'd1);
        @(posedge clk);
        #1;
        send_byte(img[4], 0);
        send_byte(img[5], 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_load(2, 0, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum keeps the CPU held; a good reload releases it.
        set_basic_image();
        run_load(2, 0, 1'b1);
        run_load(2, 2, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
